// File: rtl/ft_pkg.sv
// Shared definitions for the fault-tolerant checkpoint memory and its restore sequencer.
// The register/PC word layout lives here so both sides agree on one definition.
package ft_pkg;

  // Checkpoint layout: register words at 0..FT_NUM_REGS-1, saved PC at FT_PC_WORD.
  localparam int unsigned FT_NUM_REGS = 32;
  localparam int unsigned FT_PC_WORD  = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    ERROR
  } restore_state_e;

  // Word index to byte address on the 32-bit memory data interface.
  function automatic logic [31:0] word_to_byte_addr(input logic [5:0] word_idx);
    return {24'b0, word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/ft_restore_ctrl_if.sv
// Read-only data interface between the restore sequencer (master) and the checkpoint
// memory (slave). The memory samples addr in the grant cycle; rdata/err follow with rvalid.
interface ft_restore_ctrl_if;

  logic        req;
  logic        gnt;
  logic        rvalid;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata,
    output err
  );

endinterface

// File: rtl/ft_restore_ctrl.sv
// Restore sequencer: reads the saved register file and PC back from the checkpoint
// memory, replays the registers into the core register-file write port, then loads the PC.
module ft_restore_ctrl
  import ft_pkg::*;
#(
  parameter int unsigned NUM_REGS = FT_NUM_REGS,
  parameter int unsigned PC_WORD  = FT_PC_WORD,
  parameter bit          SKIP_X0  = 1'b1,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  ft_restore_ctrl_if.master  mem,
  output logic               rf_we_o,
  output logic [4:0]         rf_addr_o,
  output logic [31:0]        rf_wdata_o,
  output logic               pc_load_o,
  output logic [31:0]        pc_o
);

  // idx == LastIdx selects the PC word, which is always the final read.
  localparam logic [5:0] LastIdx     = 6'(NUM_REGS);
  localparam logic [5:0] PcIdx       = 6'(PC_WORD);
  localparam logic [5:0] StartIdx    = SKIP_X0 ? 6'd1 : 6'd0;
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  restore_state_e state_q;
  logic [5:0]     idx_q;
  logic [7:0]     cnt_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;
  logic           req_q;
  logic [31:0]    addr_q;
  logic           rf_we_q;
  logic [4:0]     rf_addr_q;
  logic [31:0]    rf_wdata_q;
  logic           pc_load_q;
  logic [31:0]    pc_q;

  // Memory address for a sequence index; the terminal index maps onto the PC slot.
  function automatic logic [31:0] seq_addr(input logic [5:0] i);
    return word_to_byte_addr((i == LastIdx) ? PcIdx : i);
  endfunction

  // Sequencer FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      pc_load_q  <= 1'b0;
      pc_q       <= '0;
    end else begin
      done_q    <= 1'b0;
      rf_we_q   <= 1'b0;
      pc_load_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            idx_q   <= StartIdx;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            req_q   <= 1'b1;
            addr_q  <= seq_addr(StartIdx);
            state_q <= REQ;
          end
        end
        REQ: begin
          // req/addr stay stable until granted.
          if (mem.gnt) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // rvalid takes priority over an expiring timeout in the same cycle.
          if (mem.rvalid) begin
            if (mem.err) begin
              err_q   <= 1'b1;
              state_q <= ERROR;
            end else if (idx_q < LastIdx) begin
              rf_we_q    <= 1'b1;
              rf_addr_q  <= idx_q[4:0];
              rf_wdata_q <= mem.rdata;
              idx_q      <= idx_q + 6'd1;
              req_q      <= 1'b1;
              addr_q     <= seq_addr(idx_q + 6'd1);
              state_q    <= REQ;
            end else begin
              pc_q      <= mem.rdata;
              pc_load_q <= 1'b1;
              state_q   <= DONE;
            end
          end else if (cnt_q == TimeoutLast) begin
            err_q   <= 1'b1;
            state_q <= ERROR;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        ERROR: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign mem.req    = req_q;
  assign mem.addr   = addr_q;
  assign rf_we_o    = rf_we_q;
  assign rf_addr_o  = rf_addr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign pc_load_o  = pc_load_q;
  assign pc_o       = pc_q;

endmodule
